prbs26_checker: RTL

- Downstream consumer of the 26-bit Galois LFSR pattern generator.
- Takes the generator's parallel 26-bit state word each valid cycle and self-synchronises to the sequence.
- Reports lock status and accumulates errors on a saturating counter.
- Used for link and loopback BIST of the LFSR-driven datapath.

---
 rtl/prbs26_checker.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/prbs26_checker.sv
// prbs26_checker: self-synchronising checker for the 26-bit Galois LFSR
// state-word stream. Hunts for phase, verifies LOCK_CNT consecutive
// predictions, then flywheels on its own prediction while counting errors.
// Optional build macro PRBS26_BIT_ERR_EN: err_cnt accumulates the number of
// differing bits per bad word instead of one per bad word.
module prbs26_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [1:26]      din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:26]      exp_word
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned CMP_W = CNT_W + 1;
  localparam int unsigned INC_W = 5;
  localparam int unsigned SUM_W = ((ERR_W > INC_W) ? ERR_W : INC_W) + 1;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e           state_q;
  logic [1:26]      exp_word_q;
  logic [CNT_W-1:0] match_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic [1:26]      din_next_c;
  logic [1:26]      exp_next_c;
  logic             din_zero_c;
  logic             din_match_c;
  logic             lock_hit_c;
  logic             loss_hit_c;
  logic             err_hit_c;
  logic [INC_W-1:0] err_inc_c;
  logic [SUM_W-1:0] err_sum_c;
  logic [ERR_W-1:0] err_cnt_d;

  // Generator next-state function; the all-zero word steps to bit 26 only.
  function automatic logic [1:26] lfsr_next(input logic [1:26] q);
    logic [1:26] n;
    if (q == 26'd0) begin
      n = 26'd1;
    end else begin
      n[1]     = q[26];
      n[2]     = q[1] ^ q[26];
      n[3:7]   = q[2:6];
      n[8]     = q[7] ^ q[26];
      n[9]     = q[8] ^ q[26];
      n[10:26] = q[9:25];
    end
    return n;
  endfunction

  // Predictions from the incoming word and from the flywheel register.
  always_comb begin
    din_next_c  = lfsr_next(din);
    exp_next_c  = lfsr_next(exp_word_q);
    din_zero_c  = (din == 26'd0);
    din_match_c = (din == exp_word_q);
    lock_hit_c  = ((CMP_W'(match_cnt_q) + CMP_W'(1)) == CMP_W'(LOCK_CNT));
    loss_hit_c  = ((CMP_W'(miss_cnt_q) + CMP_W'(1)) == CMP_W'(LOSS_CNT));
    err_hit_c   = din_valid && (state_q == ST_LOCKED) && !din_match_c;
  end

`ifdef PRBS26_BIT_ERR_EN
  logic [1:26] err_bits_c;

  // Error weight is the number of bits that differ from the prediction.
  always_comb begin
    err_bits_c = din ^ exp_word_q;
    err_inc_c  = '0;
    for (int i = 1; i <= 26; i++) begin
      err_inc_c = err_inc_c + INC_W'(err_bits_c[i]);
    end
  end
`else
  // Error weight is one per mismatching word.
  always_comb begin
    err_inc_c = INC_W'(1);
  end
`endif

  // Saturating accumulate; any carry above ERR_W pins the count at all-ones.
  always_comb begin
    err_sum_c = SUM_W'(err_cnt_q) + SUM_W'(err_inc_c);
    if (err_sum_c[SUM_W-1:ERR_W] != '0) begin
      err_cnt_d = '1;
    end else begin
      err_cnt_d = err_sum_c[ERR_W-1:0];
    end
  end

  // Hunt / verify / locked state machine with registered lock flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      exp_word_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
    end else if (din_valid) begin
      case (state_q)
        ST_HUNT: begin
          // A zero word is the generator's reset value and has no phase.
          if (!din_zero_c) begin
            exp_word_q  <= din_next_c;
            match_cnt_q <= '0;
            state_q     <= ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          exp_word_q <= din_next_c;
          if (din_match_c) begin
            match_cnt_q <= match_cnt_q + CNT_W'(1);
            if (lock_hit_c) begin
              state_q    <= ST_LOCKED;
              locked_q   <= 1'b1;
              miss_cnt_q <= '0;
            end
          end else begin
            // Reseed from the received word; zero drops back to hunting.
            match_cnt_q <= '0;
            if (din_zero_c) begin
              state_q <= ST_HUNT;
            end
          end
        end
        ST_LOCKED: begin
          // Flywheel: prediction advances independently of din.
          exp_word_q <= exp_next_c;
          if (din_match_c) begin
            miss_cnt_q <= '0;
          end else if (loss_hit_c) begin
            miss_cnt_q <= '0;
            state_q    <= ST_HUNT;
            locked_q   <= 1'b0;
          end else begin
            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q  <= ST_HUNT;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  // Error flag and counter; clear wins over a simultaneous increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= err_hit_c;
      if (clr_cnt) begin
        err_cnt_q <= '0;
      end else if (err_hit_c) begin
        err_cnt_q <= err_cnt_d;
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign exp_word  = exp_word_q;

endmodule
